alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream command stage for alu_top. Accepts ALU commands (operand1, operand2, select) over a
//  valid/ready interface and buffers them in a DEPTH-entry FIFO. Issues one command at a time to
//  alu_top, captures alu_top's registered result, and returns it on a valid/ready response port.
//  Sits between the command source (testbench or controller) and alu_top; shares clk/reset with it.
// PARAMETERS
//  N      4  operand width; the result width is 2*N (matches alu_top N)
//  DEPTH  4  command FIFO entries; must be a power of 2 and >= 2
// PORTS
//  clk           in   1      clock
//  reset         in   1      reset, asynchronous, active-high
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      FIFO can accept a command
//  cmd_op1       in   N      operand1
//  cmd_op2       in   N      operand2
//  cmd_sel       in   4      ALU select code, passed through unmodified
//  alu_operand1  out  N      registered, to alu_top.operand1
//  alu_operand2  out  N      registered, to alu_top.operand2
//  alu_select    out  4      registered, to alu_top.select
//  alu_result    in   2N     from alu_top.result (1-cycle registered output)
//  rsp_valid     out  1      response present
//  rsp_ready     in   1      consumer accepts response
//  rsp_result    out  2N     captured ALU result
//  fifo_count    out  $clog2(DEPTH)+1  commands buffered, not yet issued
// BEHAVIOUR
//  Reset (async): FIFO flushed (count 0, pointers 0), state IDLE.
//   All outputs are 0, except cmd_ready, which is 1.
//  Command push: occurs when cmd_valid && cmd_ready at the clk edge. cmd_ready = (fifo_count != DEPTH).
//   A push and a pop in the same cycle are both honoured. When the FIFO is full, cmd_ready=0 even if a pop occurs that cycle.
//  FSM states: IDLE, ISSUE, CAPTURE, RESP.
//   IDLE:    if FIFO non-empty -> load alu_* regs from the FIFO head, pop, go to ISSUE.
//   ISSUE:   alu_* held stable; alu_top registers its result at this edge -> CAPTURE.
//   CAPTURE: rsp_result <= alu_result -> RESP.
//   RESP:    rsp_valid=1; rsp_result is held until rsp_valid && rsp_ready.
//            On that handshake: if FIFO non-empty, load+pop and go to ISSUE; else go to IDLE.
//  alu_* regs keep the last issued command between commands; they are never cleared except by reset.
//  Latency: with the FSM idle, rsp_valid rises exactly 3 clk edges after the accepting edge.
//   Back-to-back throughput is 1 response per 3 cycles when rsp_ready is held at 1.
//  Responses are returned in command order. The block applies no width change: rsp_result = alu_result bits [2N-1:0].
//  Wrap-around: FIFO pointers wrap modulo DEPTH; the count disambiguates full from empty.
//  Reset mid-operation: any in-flight command and any unconsumed response are dropped; rsp_valid falls immediately.
// CONFIGURATION
//  Macro ALU_SEQ_STATS_EN:
//   Defined: adds output port done_count [15:0]. It increments on each rsp handshake, saturates at 16'hFFFF and resets to 0.
//   Also adds output port stall_count [15:0], which counts cycles with cmd_valid && !cmd_ready, saturating the same way.
//   Undefined: these ports and their counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package alu_seq_pkg:
//   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} seq_state_t;
//   typedef struct packed {op1, op2, sel} alu_cmd_t, parameterised through localparam N_DEF=4.
//  Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t, DEPTH entries, push/pop/count/full/empty,
//   async active-high reset. The top level holds the FSM, the alu_* registers and the rsp register.
// TESTING (bench instantiates alu_cmd_sequencer + alu_top #(N=4); golden = alu_top model)
//  1. reset -> cmd_ready=1, rsp_valid=0, fifo_count=0, alu_operand1/2=0, alu_select=0.
//  2. single cmd op1=4'h3, op2=4'h5, sel=4'h0, rsp_ready=1 -> alu_* = 3/5/0 for one ISSUE cycle;
//     rsp_valid rises 3 edges after accept; rsp_result = model(3,5,0).
//  3. push 5 cmds back-to-back with rsp_ready=0 -> first cmd issued, next 4 fill FIFO;
//     cmd_ready=0 at fifo_count=4, 6th push blocked; releasing rsp_ready drains 5 responses in order.
//  4. hold a response with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_result stable; no new issue.
//  5. assert reset during CAPTURE with 2 cmds queued -> rsp_valid=0, fifo_count=0 next cycle;
//     after release, a fresh cmd completes normally.
//  6. ALU_SEQ_STATS_EN: 3 responses plus 2 blocked-push cycles -> done_count=3, stall_count=2; preload 16'hFFFF -> holds.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM state encoding and the default-width command record.
package alu_seq_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} seq_state_t;

  typedef struct packed {
    logic [N_DEF-1:0] op1;
    logic [N_DEF-1:0] op2;
    logic [3:0]       sel;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of packed ALU commands; pointers wrap modulo DEPTH, count separates full from empty.
module alu_cmd_fifo #(
  parameter int W     = $bits(alu_seq_pkg::alu_cmd_t),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to alu_top and returns each registered result.
// Optional macro ALU_SEQ_STATS_EN adds saturating done_count / stall_count outputs.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [N-1:0]           cmd_op1,
  input  logic [N-1:0]           cmd_op2,
  input  logic [3:0]             cmd_sel,
  output logic [N-1:0]           alu_operand1,
  output logic [N-1:0]           alu_operand2,
  output logic [3:0]             alu_select,
  input  logic [2*N-1:0]         alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*N-1:0]         rsp_result,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]            done_count,
  output logic [15:0]            stall_count,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  typedef struct packed {
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic [3:0]   sel;
  } cmd_t;

  seq_state_t state;
  cmd_t       push_cmd;
  cmd_t       head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign push_cmd  = '{op1: cmd_op1, op2: cmd_op2, sel: cmd_sel};
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // Head is taken whenever the FSM is free to start a new command.
  assign pop       = !empty && ((state == IDLE) || (state == RESP && rsp_ready));

  alu_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_select   <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_operand1 <= head.op1;
            alu_operand2 <= head.op2;
            alu_select   <= head.sel;
            state        <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          rsp_result <= alu_result;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              alu_operand1 <= head.op1;
              alu_operand2 <= head.op2;
              alu_select   <= head.sel;
              state        <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_count  <= '0;
      stall_count <= '0;
    end else begin
      if (rsp_valid && rsp_ready)  done_count  <= sat_inc(done_count);
      if (cmd_valid && !cmd_ready) stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer driving a behavioural registered ALU and a queue-based reference.
module tb_alu_cmd_sequencer;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_op1;
  logic [N-1:0] cmd_op2;
  logic [3:0]   cmd_sel;
  logic [N-1:0] alu_operand1;
  logic [N-1:0] alu_operand2;
  logic [3:0]   alu_select;
  logic [2*N-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2*N-1:0] rsp_result;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]  done_count;
  logic [15:0]  stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] got_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op1      (cmd_op1),
    .cmd_op2      (cmd_op2),
    .cmd_sel      (cmd_sel),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_select   (alu_select),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
`ifdef ALU_SEQ_STATS_EN
    .done_count   (done_count),
    .stall_count  (stall_count),
`endif
    .fifo_count   (fifo_count)
  );

  // Golden ALU behaviour, used both by the registered alu_top stand-in and by the reference queue.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [7:0] ea, eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (s)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea * eb;
      4'd3:    return ea & eb;
      4'd4:    return ea | eb;
      4'd5:    return ea ^ eb;
      default: return {a, b};
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) alu_result <= '0;
    else       alu_result <= alu_f(alu_operand1, alu_operand2, alu_select);
  end

  // Reference: every accepted command yields alu_f of its fields, in acceptance order.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      got_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) exp_q.push_back(alu_f(cmd_op1, cmd_op2, cmd_sel));
      if (rsp_valid && rsp_ready) got_q.push_back(rsp_result);
    end
  end

  task automatic push_random();
    cmd_op1 = 4'($urandom);
    cmd_op2 = 4'($urandom);
    cmd_sel = 4'($urandom_range(0, 7));
    cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op1 = '0; cmd_op2 = '0; cmd_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    checks++; if (alu_operand1 !== 4'd0 || alu_operand2 !== 4'd0) begin failures++; $display("FAIL reset_alu_ops got=%h/%h exp=0/0", alu_operand1, alu_operand2); end
    checks++; if (alu_select !== 4'd0) begin failures++; $display("FAIL reset_alu_select got=%h exp=0", alu_select); end
    checks++; if (rsp_result !== 8'd0) begin failures++; $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1 || fifo_count !== 3'd0) begin failures++; $display("FAIL post_reset_idle ready=%b count=%0d exp=1/0", cmd_ready, fifo_count); end
  endtask

  task automatic test_single();
    logic [7:0] g, e;
    rsp_ready = 1'b1;
    cmd_op1 = 4'h3; cmd_op2 = 4'h5; cmd_sel = 4'h0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_accept count=%0d rsp_valid=%b exp=1/0", fifo_count, rsp_valid); end
    @(posedge clk); #1;
    checks++; if (alu_operand1 !== 4'h3 || alu_operand2 !== 4'h5 || alu_select !== 4'h0) begin failures++; $display("FAIL single_issue got=%h/%h/%h exp=3/5/0", alu_operand1, alu_operand2, alu_select); end
    checks++; if (fifo_count !== 3'd0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_issue_state count=%0d rsp_valid=%b exp=0/0", fifo_count, rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_latency rsp_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_result !== 8'd8) begin failures++; $display("FAIL single_result got=%h exp=08", rsp_result); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
    checks++; if (alu_operand1 !== 4'h3 || alu_operand2 !== 4'h5) begin failures++; $display("FAIL single_alu_hold got=%h/%h exp=3/5", alu_operand1, alu_operand2); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_rsp_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL single_order got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_random();
      @(posedge clk); #1;
    end
    checks++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_full count=%0d ready=%b exp=4/0", fifo_count, cmd_ready); end
    push_random();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || exp_q.size() != 5) begin failures++; $display("FAIL b2b_blocked count=%0d ready=%b accepted=%0d exp=4/0/5", fifo_count, cmd_ready, exp_q.size()); end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && got_q.size() < 5; i++) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL b2b_drain got=%0d exp=5", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_order got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_hold();
    logic [7:0] held, g, e;
    rsp_ready = 1'b0;
    push_random();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) begin @(posedge clk); #1; end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_rsp_valid got=%b exp=1", rsp_valid); end
    held = rsp_result;
    push_random();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held || fifo_count !== 3'd1) begin
        failures++; $display("FAIL hold_stable cyc=%0d valid=%b result=%h count=%0d exp=1/%h/1", i, rsp_valid, rsp_result, fifo_count, held);
      end
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && got_q.size() < 2; i++) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL hold_drain got=%0d exp=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL hold_order got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] g, e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_random();
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_pre count=%0d valid=%b exp=2/0", fifo_count, rsp_valid); end
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rstmid_async valid=%b count=%0d exp=0/0", rsp_valid, fifo_count); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_next valid=%b count=%0d ready=%b exp=0/0/1", rsp_valid, fifo_count, cmd_ready); end
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    push_random();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 1; i++) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin failures++; $display("FAIL rstmid_fresh got=%0d accepted=%0d exp=1/1", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rstmid_result got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) push_random();
      else cmd_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      checks++;
      if (fifo_count > 3'd4 || cmd_ready !== (fifo_count != 3'd4)) begin
        failures++; $display("FAIL rand_ready cyc=%0d count=%0d ready=%b", i, fifo_count, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) begin @(posedge clk); #1; end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_drain got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rand_order got=%h exp=%h", g, e); end
    end
  endtask

`ifdef ALU_SEQ_STATS_EN
  task automatic test_stats();
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_random();
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && got_q.size() < 3; i++) begin @(posedge clk); #1; end
    checks++; if (done_count !== 16'd3 || stall_count !== 16'd0) begin failures++; $display("FAIL stats_done done=%0d stall=%0d exp=3/0", done_count, stall_count); end
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_random();
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checks++; if (done_count !== 16'd3 || stall_count !== 16'd2) begin failures++; $display("FAIL stats_stall done=%0d stall=%0d exp=3/2", done_count, stall_count); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && got_q.size() < 8; i++) begin @(posedge clk); #1; end
    checks++; if (done_count !== 16'd8) begin failures++; $display("FAIL stats_final done=%0d exp=8", done_count); end
    got_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef ALU_SEQ_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
